// File: rtl/counter_param_updown.sv
// Parametrised up/down counter: load, programmable modulus, wrap/saturate, compare match, sticky flags.
// Optional step prescaler is built only when COUNTER_PRESCALE_EN is defined.
module counter_param_updown #(
    parameter int                 WIDTH      = 12,
    parameter logic [WIDTH-1:0]   MAX_VAL    = {WIDTH{1'b1}},
    parameter int                 PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  up_down,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      data,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  clr_flags,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  match,
    output logic                  ovf,
    output logic                  unf
);

    if (WIDTH < 2 || PRESCALE_W < 1) begin : g_cfg_check
        $error("counter_param_updown: WIDTH must be >= 2 and PRESCALE_W >= 1");
    end

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_p0;
    logic             tc_p0;
    logic             ovf_p0;
    logic             unf_p0;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             hit_max;
    logic             hit_zero;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        return (d > MAX_VAL) ? MAX_VAL : d;
    endfunction

    // Boundaries are equality compares so non-power-of-two moduli never roll over naturally.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                    input logic up, input logic sat);
        if (up) begin
            if (c == MAX_VAL) return sat ? MAX_VAL : '0;
            return c + ONE;
        end
        if (c == '0) return sat ? '0 : MAX_VAL;
        return c - ONE;
    endfunction

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_p0;
    logic                  div_hit;

    assign div_hit = (div_p0 == prescale);
    assign step    = enable & ~load & div_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_p0 <= '0;
        end else if (load) begin
            div_p0 <= '0;
        end else if (enable) begin
            div_p0 <= div_hit ? '0 : div_p0 + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign step = enable & ~load;
`endif

    assign at_max   = (count_p0 == MAX_VAL);
    assign at_zero  = (count_p0 == '0);
    assign hit_max  = step & up_down & at_max;
    assign hit_zero = step & ~up_down & at_zero;

    // Stage p0: count, terminal pulse and sticky flags; a flag set beats a same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_p0 <= '0;
            tc_p0    <= 1'b0;
            ovf_p0   <= 1'b0;
            unf_p0   <= 1'b0;
        end else begin
            tc_p0  <= hit_max | hit_zero;
            ovf_p0 <= hit_max  | (ovf_p0 & ~clr_flags);
            unf_p0 <= hit_zero | (unf_p0 & ~clr_flags);
            if (load) begin
                count_p0 <= clamp_load(data);
            end else if (step) begin
                count_p0 <= next_count(count_p0, up_down, sat_mode);
            end
        end
    end

    assign count = count_p0;
    assign tc    = tc_p0;
    assign ovf   = ovf_p0;
    assign unf   = unf_p0;
    assign match = (count_p0 == cmp_val);

endmodule
